// File: rtl/cmos_frame_buf_sched_pkg.sv
// Shared types for the CMOS frame-buffer bank scheduler and related camera blocks.
package cmos_frame_buf_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } wr_state_e;

  localparam int NUM_BUF_DEF = 4;
  localparam int IDX_W_DEF   = 2;

  typedef logic [IDX_W_DEF-1:0] bank_idx_t;

endpackage

// File: rtl/cmos_vsync_edge.sv
// Two-flop synchronizer for the raw camera vsync plus a one-cycle rising-edge pulse.
module cmos_vsync_edge (
  input  logic pclk,
  input  logic rst,
  input  logic i_vsync,
  output logic o_rise
);

  logic r_s0;
  logic r_s1;
  logic r_s2;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s0 <= i_vsync;
      r_s1 <= r_s0;
      r_s2 <= r_s1;
    end
  end

  assign o_rise = r_s1 & ~r_s2;

endmodule

// File: rtl/cmos_frame_buf_sched.sv
// Frame-buffer bank scheduler: rotates write banks on camera frame start and hands
// the newest complete frame to the display reader, never writing a displayed/queued bank.
module cmos_frame_buf_sched
  import cmos_frame_buf_sched_pkg::*;
#(
  parameter int NUM_BUF = NUM_BUF_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cmos_vsync,
  input  logic             write_req_ack,
  input  logic             read_frame_start,
  output logic             write_req,
  output logic [IDX_W-1:0] write_addr_index,
  output logic [IDX_W-1:0] read_addr_index,
  output logic             read_valid,
  output logic [CNT_W-1:0] frames_written,
  output logic [CNT_W-1:0] frames_dropped
);

  wr_state_e        r_state;
  logic             r_write_req;
  logic [IDX_W-1:0] r_write_addr_index;
  logic [IDX_W-1:0] r_read_addr_index;
  logic             r_read_valid;
  logic [IDX_W-1:0] r_ready_idx;
  logic             r_ready_valid;
  logic [CNT_W-1:0] r_frames_written;
  logic [CNT_W-1:0] r_frames_dropped;

  logic             w_vs_rise;
  logic             w_promote;
  logic             w_handover;
  logic [IDX_W-1:0] w_rd_idx_nxt;
  logic             w_rd_v_nxt;
  logic [IDX_W-1:0] w_rdy_idx_nxt;
  logic             w_rdy_v_nxt;
  logic [IDX_W-1:0] w_pick;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // First bank after cur (with wrap) that is neither displayed nor queued for display.
  function automatic logic [IDX_W-1:0] pick_bank(
    input logic [IDX_W-1:0] cur,
    input logic [IDX_W-1:0] rd_idx,
    input logic             rd_v,
    input logic [IDX_W-1:0] rdy_idx,
    input logic             rdy_v
  );
    logic [IDX_W-1:0] cand;
    logic             found;
    pick_bank = cur;
    found     = 1'b0;
    for (int k = 1; k <= NUM_BUF; k++) begin
      cand = IDX_W'((int'(cur) + k) % NUM_BUF);
      if (!found && !(rd_v && cand == rd_idx) && !(rdy_v && cand == rdy_idx)) begin
        pick_bank = cand;
        found     = 1'b1;
      end
    end
  endfunction

  cmos_vsync_edge u_vsync_edge (
    .pclk    (pclk),
    .rst     (rst),
    .i_vsync (cmos_vsync),
    .o_rise  (w_vs_rise)
  );

  // Post-update read/ready view: the reader takes the old ready bank before a promotion lands.
  always_comb begin
    w_promote     = (r_state == ST_ACTIVE) && w_vs_rise;
    w_handover    = read_frame_start && r_ready_valid;
    w_rd_idx_nxt  = w_handover ? r_ready_idx : r_read_addr_index;
    w_rd_v_nxt    = r_read_valid | w_handover;
    w_rdy_idx_nxt = w_promote ? r_write_addr_index : r_ready_idx;
    w_rdy_v_nxt   = w_promote | (r_ready_valid & ~w_handover);
    w_pick        = pick_bank(r_write_addr_index, w_rd_idx_nxt, w_rd_v_nxt,
                              w_rdy_idx_nxt, w_rdy_v_nxt);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state            <= ST_IDLE;
      r_write_req        <= 1'b0;
      r_write_addr_index <= IDX_W'(NUM_BUF - 1);
      r_read_addr_index  <= '0;
      r_read_valid       <= 1'b0;
      r_ready_idx        <= '0;
      r_ready_valid      <= 1'b0;
      r_frames_written   <= '0;
      r_frames_dropped   <= '0;
    end else begin
      r_read_addr_index <= w_rd_idx_nxt;
      r_read_valid      <= w_rd_v_nxt;
      r_ready_idx       <= w_rdy_idx_nxt;
      r_ready_valid     <= w_rdy_v_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_vs_rise && enable) begin
            r_write_addr_index <= w_pick;
            r_write_req        <= 1'b1;
            r_state            <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (write_req_ack) begin
            r_write_req <= 1'b0;
            r_state     <= ST_ACTIVE;
          end else if (w_vs_rise) begin
            r_frames_dropped <= sat_inc(r_frames_dropped);
          end
        end
        ST_ACTIVE: begin
          if (w_vs_rise) begin
            r_frames_written <= sat_inc(r_frames_written);
            if (enable) begin
              r_write_addr_index <= w_pick;
              r_write_req        <= 1'b1;
              r_state            <= ST_REQ;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign write_req        = r_write_req;
  assign write_addr_index = r_write_addr_index;
  assign read_addr_index  = r_read_addr_index;
  assign read_valid       = r_read_valid;
  assign frames_written   = r_frames_written;
  assign frames_dropped   = r_frames_dropped;

endmodule

// File: tb/tb_cmos_frame_buf_sched.sv
// Scoreboard bench for cmos_frame_buf_sched: a frame-level reference model predicts the
// outputs after every pclk edge; a monitor compares them on the falling edge.
module tb_cmos_frame_buf_sched;

  localparam int NB = 3;
  localparam int IW = 2;
  localparam int CW = 4;

  logic          pclk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          cmos_vsync = 1'b0;
  logic          write_req_ack = 1'b0;
  logic          read_frame_start = 1'b0;
  logic          write_req;
  logic [IW-1:0] write_addr_index;
  logic [IW-1:0] read_addr_index;
  logic          read_valid;
  logic [CW-1:0] frames_written;
  logic [CW-1:0] frames_dropped;

  cmos_frame_buf_sched #(.NUM_BUF(NB), .IDX_W(IW), .CNT_W(CW)) dut (
    .pclk             (pclk),
    .rst              (rst),
    .enable           (enable),
    .cmos_vsync       (cmos_vsync),
    .write_req_ack    (write_req_ack),
    .read_frame_start (read_frame_start),
    .write_req        (write_req),
    .write_addr_index (write_addr_index),
    .read_addr_index  (read_addr_index),
    .read_valid       (read_valid),
    .frames_written   (frames_written),
    .frames_dropped   (frames_dropped)
  );

  always #5 pclk = ~pclk;

  int cyc_cnt = 0;
  always @(posedge pclk) cyc_cnt++;

  typedef struct {
    int            cyc;
    logic          req;
    logic [IW-1:0] wi;
    logic [IW-1:0] ri;
    logic          rv;
    logic [CW-1:0] fw;
    logic [CW-1:0] fd;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  // Reference model: frame-level view of the scheduler.
  bit m_v0, m_v1, m_v2;
  bit m_requesting, m_writing;
  int m_wr, m_rd, m_rdy, m_fw, m_fd, m_req_age;
  bit m_rd_v, m_rdy_v;

  function automatic int sat(input int v);
    return (v < (1 << CW) - 1) ? v + 1 : v;
  endfunction

  function automatic int pick_free();
    int c;
    for (int k = 1; k <= NB; k++) begin
      c = (m_wr + k) % NB;
      if (!(m_rd_v && c == m_rd) && !(m_rdy_v && c == m_rdy)) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_v0 = 0; m_v1 = 0; m_v2 = 0;
    m_requesting = 0; m_writing = 0;
    m_wr = NB - 1; m_rd = 0; m_rdy = 0; m_fw = 0; m_fd = 0; m_req_age = 0;
    m_rd_v = 0; m_rdy_v = 0;
  endtask

  task automatic model_edge(input bit v, input bit en, input bit ack, input bit rfs);
    bit rise;
    bit start;
    rise = m_v1 && !m_v2;
    m_v2 = m_v1; m_v1 = m_v0; m_v0 = v;
    if (rfs && m_rdy_v) begin
      m_rd = m_rdy; m_rd_v = 1; m_rdy_v = 0;
    end
    start = 0;
    if (m_requesting) begin
      if (ack) begin
        m_requesting = 0; m_writing = 1;
      end else if (rise) begin
        m_fd = sat(m_fd);
      end
    end else if (m_writing) begin
      if (rise) begin
        m_rdy = m_wr; m_rdy_v = 1; m_fw = sat(m_fw);
        m_writing = 0;
        start = en;
      end
    end else begin
      start = rise && en;
    end
    if (start) begin
      m_wr = pick_free(); m_requesting = 1; m_req_age = 0;
    end else if (m_requesting) begin
      m_req_age++;
    end
  endtask

  task automatic push_exp(input int t);
    exp_t e;
    e.cyc = t;
    e.req = m_requesting;
    e.wi  = IW'(m_wr);
    e.ri  = IW'(m_rd);
    e.rv  = m_rd_v;
    e.fw  = CW'(m_fw);
    e.fd  = CW'(m_fd);
    q.push_back(e);
  endtask

  task automatic step(input bit v, input bit en, input bit ack, input bit rfs);
    cmos_vsync = v; enable = en; write_req_ack = ack; read_frame_start = rfs;
    model_edge(v, en, ack, rfs);
    push_exp(cyc_cnt + 1);
    @(posedge pclk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    q.delete();
    push_exp(cyc_cnt);
    push_exp(cyc_cnt + 1);
    @(posedge pclk); #1;
    rst = 1'b0;
  endtask

  task automatic vs_pulse(input bit en, input bit ack_ok, input int rfs_at);
    bit ack;
    for (int i = 0; i < 10; i++) begin
      ack = ack_ok && m_requesting && (m_req_age >= 2);
      step(i < 2, en, ack, i == rfs_at);
    end
  endtask

  always @(negedge pclk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      n_chk++;
      if ({write_req, write_addr_index, read_addr_index, read_valid, frames_written, frames_dropped}
          === {e.req, e.wi, e.ri, e.rv, e.fw, e.fd}) begin
        n_pass++;
      end else begin
        $display("FAIL outputs cyc=%0d got req=%b wi=%0d ri=%0d rv=%b fw=%0d fd=%0d want req=%b wi=%0d ri=%0d rv=%b fw=%0d fd=%0d",
                 cyc_cnt, write_req, write_addr_index, read_addr_index, read_valid,
                 frames_written, frames_dropped, e.req, e.wi, e.ri, e.rv, e.fw, e.fd);
      end
    end
  end

  initial begin : stim
    int hi;
    int lo;
    bit en;
    #1 rst = 1'b1;
    @(posedge pclk); #1;
    do_reset();

    vs_pulse(1, 1, -1);
    vs_pulse(1, 1, -1);
    step(0, 1, 0, 1);
    vs_pulse(1, 1, -1);
    vs_pulse(1, 1, -1);
    vs_pulse(1, 0, -1);
    vs_pulse(1, 0, -1);
    vs_pulse(1, 1, -1);
    vs_pulse(1, 1, -1);
    vs_pulse(1, 1, 2);
    vs_pulse(0, 1, -1);
    vs_pulse(1, 0, -1);
    do_reset();
    vs_pulse(1, 1, -1);

    for (int f = 0; f < 250; f++) begin
      hi = $urandom_range(1, 3);
      lo = $urandom_range(0, 12);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 79) == 0) do_reset();
      for (int i = 0; i < hi + lo; i++)
        step(i < hi, en, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
    end

    repeat (3) @(posedge pclk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
